// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM controller port
// among N level-request clients. Latches the winning client's request,
// toggles mem_req, steers returned read words back and pulses c_done.
module sdram_port_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    c_req,
  input  logic [N-1:0]    c_wr,
  input  logic [N*25-1:0] c_addr,
  input  logic [N*32-1:0] c_din,
  input  logic [N*4-1:0]  c_be,
  input  logic [N*4-1:0]  c_burst,
  output logic [N-1:0]    c_rvalid,
  output logic [31:0]     c_rdata,
  output logic [N-1:0]    c_done,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            mem_wr,
  output logic [24:0]     mem_addr,
  output logic [31:0]     mem_din,
  output logic [3:0]      mem_be,
  output logic [3:0]      mem_burst,
  input  logic            mem_ready,
  input  logic [31:0]     mem_dout,
  output logic            busy,
  output logic            err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [9:0]    TO   = 10'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] rr, grant, pick;
  logic          found;
  logic [IW:0]   s;
  logic [9:0]    tcnt, tcnt_inc;
  logic          acked;

  logic          sel_wr;
  logic [24:0]   sel_addr;
  logic [31:0]   sel_din;
  logic [3:0]    sel_be, sel_burst;

  assign acked    = (mem_ack == mem_req);
  assign busy     = (state != IDLE);
  assign tcnt_inc = (tcnt == 10'h3FF) ? tcnt : tcnt + 10'd1;

  // Round-robin pick: first requester at or above rr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    s     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, rr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      if (!found && c_req[s[IW-1:0]]) begin
        found = 1'b1;
        pick  = s[IW-1:0];
      end
    end
  end

  // Field conditioning of the picked client: word-align address, writes are
  // single-word, reads always fetch full words with burst 0 meaning 1.
  always_comb begin
    sel_wr    = c_wr[pick];
    sel_addr  = {c_addr[int'(pick)*25+2 +: 23], 2'b00};
    sel_din   = c_din[int'(pick)*32 +: 32];
    sel_be    = sel_wr ? c_be[int'(pick)*4 +: 4] : 4'hF;
    sel_burst = c_burst[int'(pick)*4 +: 4];
    if (sel_wr)                sel_burst = 4'd1;
    else if (sel_burst == 4'd0) sel_burst = 4'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; DONE and HOLD each last exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found) state_nxt = WAIT;
      WAIT: if (acked) state_nxt = DONE;
      DONE: state_nxt = HOLD;
      HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: request latch and toggle, read steering, completion, timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr        <= '0;
      grant     <= '0;
      tcnt      <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_be    <= '0;
      mem_burst <= '0;
      c_rvalid  <= '0;
      c_rdata   <= '0;
      c_done    <= '0;
    end else begin
      c_rvalid <= '0;
      c_done   <= '0;
      case (state)
        IDLE: if (found) begin
          grant     <= pick;
          mem_req   <= ~mem_req;
          mem_wr    <= sel_wr;
          mem_addr  <= sel_addr;
          mem_din   <= sel_din;
          mem_be    <= sel_be;
          mem_burst <= sel_burst;
        end
        WAIT: begin
          // A ready coinciding with the ack still delivers its word; it then
          // lands in the DONE cycle alongside c_done.
          if (mem_ready) begin
            c_rdata         <= mem_dout;
            c_rvalid[grant] <= 1'b1;
          end
          if (acked) c_done[grant] <= 1'b1;
          tcnt <= tcnt_inc;
          if (tcnt_inc >= TO) err <= 1'b1;
        end
        DONE: begin
          rr   <= (grant == LAST) ? '0 : grant + 1'b1;
          tcnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
